add_arb: RTL and testbench

ADD_ARB -- requirements
Module: add_arb

---
 rtl/add_arb_pkg.sv | 5 +
 rtl/add.sv | 8 +
 rtl/add_arb.sv | 82 ++++++++
 tb/tb_add_arb.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared FSM state encoding and datapath width for add_arb.
package add_arb_pkg;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
endpackage

// File: rtl/add.sv
// add: combinational 8-bit wrapping adder.
module add (
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    output logic [7:0] sum
);
    assign sum = in1 + in2;
endmodule

// File: rtl/add_arb.sv
// add_arb: round-robin arbiter sharing one 8-bit adder between two requesters,
// with signed-overflow flagging and saturating response counters.
module add_arb
    import add_arb_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              req1_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_sum,
    output logic              resp_ovf,
    output logic [CNT_W-1:0]  op_count,
    output logic [7:0]        ovf_count
);
    state_t state, state_nx;
    logic last_id, gnt, ovf;
    logic [DATA_W-1:0] a_q, b_q, sum;

    add u_add (.in1(a_q), .in2(b_q), .sum(sum));

    // Overflow only when like-signed operands produce an opposite-signed sum.
    assign ovf = (a_q[DATA_W-1] == b_q[DATA_W-1]) & (sum[DATA_W-1] != a_q[DATA_W-1]);
    assign gnt = (req0_valid & req1_valid) ? ~last_id : req1_valid;
    assign resp_valid = state == RESP;

    always_comb begin
        state_nx = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = req0_valid & ~gnt;
                req1_ready = req1_valid & gnt;
                state_nx = (req0_ready | req1_ready) ? CALC : IDLE;
            end
            CALC: state_nx = RESP;
            RESP: state_nx = resp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_id   <= 1'b1;
            resp_id   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            resp_sum  <= '0;
            resp_ovf  <= 1'b0;
            op_count  <= '0;
            ovf_count <= '0;
        end else begin
            state <= state_nx;
            if (req0_ready | req1_ready) begin
                a_q     <= gnt ? req1_a : req0_a;
                b_q     <= gnt ? req1_b : req0_b;
                resp_id <= gnt;
                last_id <= gnt;
            end
            if (state == CALC) begin
                resp_sum <= ovf ? '0 : sum;
                resp_ovf <= ovf;
            end
            if (resp_valid & resp_ready) begin
                op_count  <= &op_count ? op_count : op_count + 1'b1;
                ovf_count <= (&ovf_count | ~resp_ovf) ? ovf_count : ovf_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_add_arb.sv
// tb_add_arb: vector table plus hand-written sequences, scoreboarded responses.
module tb_add_arb;
    logic clk, rst_n;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic resp_valid, resp_ready, resp_id, resp_ovf;
    logic [7:0] resp_sum, ovf_count;
    logic [3:0] op_count;

    add_arb #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_sum(resp_sum), .resp_ovf(resp_ovf), .op_count(op_count), .ovf_count(ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        bit o;
    } vec_t;
    typedef struct {
        bit id;
        logic [7:0] s;
        bit o;
    } exp_t;

    vec_t tv[7];
    exp_t sb[$];
    int errors = 0, checks = 0, cyc = 0;
    int m_op = 0, m_ovf = 0;
    bit acc0, acc1, hold;
    logic [7:0] h_sum, last_sum;
    logic h_ovf, h_id, last_ovf, last_id;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input bit id, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] s;
        bit o;
        s = a + b;
        o = (a[7] == b[7]) && (s[7] != a[7]);
        model = '{id, o ? 8'h00 : s, o};
    endfunction

    // Entered at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        bit hs;
        exp_t e;
        #1;
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        hs = resp_valid && resp_ready;
        check("ready_excl", {31'd0, req0_ready & req1_ready}, 0);
        check("ready_busy", {31'd0, resp_valid & (req0_ready | req1_ready)}, 0);
        check("ready_no_valid", {31'd0, (req0_ready & ~req0_valid) | (req1_ready & ~req1_valid)}, 0);
        if (hold) begin
            check("hold_valid", {31'd0, resp_valid}, 1);
            check("hold_sum", {24'd0, resp_sum}, {24'd0, h_sum});
            check("hold_ovf", {31'd0, resp_ovf}, {31'd0, h_ovf});
            check("hold_id", {31'd0, resp_id}, {31'd0, h_id});
        end
        if (hs) begin
            if (sb.size() == 0) check("sb_unexpected_resp", 1, 0);
            else begin
                e = sb.pop_front();
                check("resp_id", {31'd0, resp_id}, {31'd0, e.id});
                check("resp_sum", {24'd0, resp_sum}, {24'd0, e.s});
                check("resp_ovf", {31'd0, resp_ovf}, {31'd0, e.o});
                last_sum = resp_sum;
                last_ovf = resp_ovf;
                last_id = resp_id;
            end
        end
        hold = resp_valid && !resp_ready;
        h_sum = resp_sum;
        h_ovf = resp_ovf;
        h_id = resp_id;
        if (acc0) sb.push_back(model(1'b0, req0_a, req0_b));
        if (acc1) sb.push_back(model(1'b1, req1_a, req1_b));
        @(negedge clk);
        cyc++;
        if (hs) begin
            m_op = (m_op == 15) ? 15 : m_op + 1;
            if (last_ovf) m_ovf = (m_ovf == 255) ? 255 : m_ovf + 1;
        end
        check("op_count", {28'd0, op_count}, m_op);
        check("ovf_count", {24'd0, ovf_count}, m_ovf);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst_resp_valid", {31'd0, resp_valid}, 0);
        check("rst_resp_sum", {24'd0, resp_sum}, 0);
        check("rst_resp_ovf", {31'd0, resp_ovf}, 0);
        check("rst_resp_id", {31'd0, resp_id}, 0);
        check("rst_op_count", {28'd0, op_count}, 0);
        check("rst_ovf_count", {24'd0, ovf_count}, 0);
        check("rst_req0_ready", {31'd0, req0_ready}, 1);
        check("rst_req1_ready", {31'd0, req1_ready}, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        sb.delete();
        m_op = 0;
        m_ovf = 0;
        hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(output int gid);
        gid = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (acc0) begin gid = 0; break; end
            if (acc1) begin gid = 1; break; end
        end
        if (gid < 0) check("grant_timeout", 1, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("drain_left", sb.size(), 0);
    endtask

    task automatic run_op(input bit id, input logic [7:0] a, input logic [7:0] b);
        int g;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        wait_grant(g);
        check("op_grant", g, {31'd0, id});
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("calc_no_resp", {31'd0, resp_valid}, 0);
        tick();
        check("resp_valid_up", {31'd0, resp_valid}, 1);
        tick();
    endtask

    initial begin
        int g, prev;
        rst_n = 1'b0;
        {req0_valid, req1_valid, resp_ready} = '0;
        {req0_a, req0_b, req1_a, req1_b} = '0;
        tv[0] = '{1'b0, 8'h05, 8'h03, 8'h08, 1'b0};
        tv[1] = '{1'b1, 8'h7F, 8'h01, 8'h00, 1'b1};
        tv[2] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b0};
        tv[3] = '{1'b1, 8'h80, 8'hFF, 8'h00, 1'b1};
        tv[4] = '{1'b0, 8'h40, 8'h40, 8'h00, 1'b1};
        tv[5] = '{1'b1, 8'hC0, 8'hC0, 8'h80, 1'b0};
        tv[6] = '{1'b0, 8'h7F, 8'h80, 8'hFF, 1'b0};
        @(negedge clk);
        do_reset();
        resp_ready = 1'b1;

        foreach (tv[i]) begin
            run_op(tv[i].id, tv[i].a, tv[i].b);
            check("tv_sum", {24'd0, last_sum}, {24'd0, tv[i].s});
            check("tv_ovf", {31'd0, last_ovf}, {31'd0, tv[i].o});
            check("tv_id", {31'd0, last_id}, {31'd0, tv[i].id});
            if (i == 0) check("first_op_count", {28'd0, op_count}, 1);
        end
        check("tv_ovf_total", {24'd0, ovf_count}, 3);

        // Response back-pressure: everything frozen while resp_ready is low.
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h20;
        wait_grant(g);
        req0_valid = 1'b0;
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {31'd0, resp_valid}, 1);
            check("bp_ready", {30'd0, req0_ready, req1_ready}, 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
        tick();
        check("bp_sum", {24'd0, last_sum}, 8'h30);
        check("bp_idle", {30'd0, resp_valid, req0_ready | req1_ready}, 0);

        // Reset while an operation sits in CALC.
        req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h02;
        wait_grant(g);
        req1_valid = 1'b0;
        do_reset();
        req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h03;
        req1_valid = 1'b1; req1_a = 8'h7F; req1_b = 8'h01;
        wait_grant(g);
        check("post_rst_grant", g, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Round robin with both requesters continuously valid from reset.
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_grant(g);
            check("rr_id", g, k % 2);
            if (k > 0) check("rr_gap", cyc - prev, 3);
            prev = cyc;
        end

        // Keep issuing until op_count saturates.
        for (int k = 0; k < 14; k++) wait_grant(g);
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();
        check("op_sat", {28'd0, op_count}, 4'hF);
        check("ovf_after_sat", {24'd0, ovf_count}, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
